// File: rtl/lfsr_random_gen.sv
// ---------------------------------------------------------------------------
// lfsr_random_gen
//
// Purpose:
//   Fibonacci LFSR with a rejection-sampling draw engine. While no map is
//   loaded the LFSR free-runs every cycle, so the value it holds when play
//   starts depends on player timing. A draw request steps the LFSR once per
//   cycle until the low OUT_W bits land in 1..MAX_VAL. If MAX_TRIES
//   consecutive candidates are rejected, the draw returns 1 with fallback set.
//
// Parameters:
//   WIDTH     LFSR state width (3..32)
//   TAPS      feedback tap mask over the state bits
//   SEED      non-zero reset / lockup-recovery state
//   OUT_W     draw output width (1..WIDTH)
//   MAX_VAL   largest legal draw; the legal range is 1..MAX_VAL
//   MAX_TRIES attempt limit before falling back (1..255)
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   map_loaded  low = LFSR advances every cycle
//   req         draw request (sampled in IDLE only)
//   ready       high while idle
//   valid       draw result available (held until ack)
//   ack         consumer accepts the result
//   value       drawn number
//   fallback    result came from the attempt limit
//   state       raw LFSR state (debug)
//   seed_load   (RNG_SEED_LOAD_EN only) load seed_in into the LFSR
//   seed_in     (RNG_SEED_LOAD_EN only) seed value; zero maps to SEED
//
// Configuration macro: RNG_SEED_LOAD_EN adds the seed_load/seed_in ports.
// ---------------------------------------------------------------------------
module lfsr_random_gen #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter int unsigned      SEED      = 1,
    parameter int unsigned      OUT_W     = 4,
    parameter int unsigned      MAX_VAL   = 9,
    parameter int unsigned      MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             map_loaded,
    input  logic             req,
    output logic             ready,
    output logic             valid,
    input  logic             ack,
    output logic [OUT_W-1:0] value,
    output logic             fallback,
    output logic [WIDTH-1:0] state
`ifdef RNG_SEED_LOAD_EN
    ,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] SEED_V   = WIDTH'(SEED);
    localparam logic [OUT_W-1:0] MAX_V    = OUT_W'(MAX_VAL);
    localparam logic [7:0]       LAST_TRY = 8'(MAX_TRIES - 1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] shift_val;
    logic             fb;
    logic             advance;

    logic [1:0]       fsm_q, fsm_d;
    logic [7:0]       tries_q, tries_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic             fallback_q, fallback_d;
    logic [OUT_W-1:0] cand;
    logic             cand_ok;

    // LFSR next state. Priority: seed load > lockup recovery > advance > hold.
    always_comb begin
        fb        = ^(state_q & TAPS);
        shift_val = {state_q[WIDTH-2:0], fb};
        advance   = !map_loaded || (fsm_q == ST_DRAW);
        state_d   = state_q;
        if (state_q == '0) begin
            // All-zero is a fixed point of an XOR LFSR; kick it back out.
            state_d = SEED_V;
        end else if (advance) begin
            state_d = shift_val;
        end
`ifdef RNG_SEED_LOAD_EN
        if (seed_load) begin
            state_d = (seed_in == '0) ? SEED_V : seed_in;
        end
`endif
    end

    // Draw FSM. The candidate is taken from the current state, the same
    // cycle the LFSR steps past it, so an accepted value is never reused.
    always_comb begin
        cand       = state_q[OUT_W-1:0];
        cand_ok    = (cand != '0) && (cand <= MAX_V);
        fsm_d      = fsm_q;
        tries_d    = tries_q;
        value_d    = value_q;
        fallback_d = fallback_q;
        case (fsm_q)
            ST_IDLE: begin
                if (req) begin
                    fsm_d   = ST_DRAW;
                    tries_d = 8'd0;
                end
            end
            ST_DRAW: begin
                if (cand_ok) begin
                    value_d    = cand;
                    fallback_d = 1'b0;
                    fsm_d      = ST_DONE;
                end else if (tries_q == LAST_TRY) begin
                    // This rejection is the MAX_TRIES-th in a row.
                    value_d    = OUT_W'(1);
                    fallback_d = 1'b1;
                    fsm_d      = ST_DONE;
                end else begin
                    tries_d = tries_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEED_V;
            fsm_q      <= ST_IDLE;
            tries_q    <= 8'd0;
            value_q    <= '0;
            fallback_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fsm_q      <= fsm_d;
            tries_q    <= tries_d;
            value_q    <= value_d;
            fallback_q <= fallback_d;
        end
    end

    assign ready    = (fsm_q == ST_IDLE);
    assign valid    = (fsm_q == ST_DONE);
    assign value    = value_q;
    assign fallback = fallback_q;
    assign state    = state_q;

endmodule
